// File: rtl/bcd_7seg_scanner.sv
// Time-multiplexed 3-digit common-anode seven-segment scanner with per-frame BCD snapshot
// and optional leading-zero blanking; the fourth anode is never driven.
module bcd_7seg_scanner #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [11:0] BCD,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        FRAME
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        DIG_UNITS    = 2'd0,
        DIG_TENS     = 2'd1,
        DIG_HUNDREDS = 2'd2
    } dig_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    dig_e             dig_q, dig_d;
    logic [11:0]      snap_q, snap_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             frame_q, frame_d;

    logic             tick_c;
    logic             capture_c;
    logic             blank_c;
    logic [3:0]       nib_c;

    // Active-low gfedcba decode; non-BCD nibbles render as a dash.
    function automatic logic [6:0] decode7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q   <= '0;
            dig_q   <= DIG_UNITS;
            snap_q  <= '0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        dig_d     = dig_q;
        snap_d    = snap_q;
        an_d      = 4'b1111;
        seg_d     = 7'b1111111;
        tick_c    = (cnt_q == CNT_MAX);
        capture_c = 1'b0;
        blank_c   = 1'b0;
        nib_c     = snap_q[3:0];

        if (tick_c) begin
            cnt_d = '0;
            case (dig_q)
                DIG_UNITS: dig_d = DIG_TENS;
                DIG_TENS:  dig_d = DIG_HUNDREDS;
                default:   dig_d = DIG_UNITS;
            endcase
        end

        // Snapshot only at the end of the hundreds slot so a frame never mixes two values.
        capture_c = tick_c && (dig_q == DIG_HUNDREDS);
        if (capture_c) begin
            snap_d = BCD;
        end

        case (dig_q)
            DIG_TENS: begin
                nib_c   = snap_q[7:4];
                blank_c = BLANK_LZ && (snap_q[11:8] == 4'd0) && (snap_q[7:4] == 4'd0);
                an_d    = 4'b1101;
            end
            DIG_HUNDREDS: begin
                nib_c   = snap_q[11:8];
                blank_c = BLANK_LZ && (snap_q[11:8] == 4'd0);
                an_d    = 4'b1011;
            end
            default: begin
                nib_c   = snap_q[3:0];
                blank_c = 1'b0;
                an_d    = 4'b1110;
            end
        endcase

        if (blank_c) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
        end else begin
            seg_d = decode7(nib_c);
        end

        frame_d = capture_c;
    end

    assign AN    = an_q;
    assign SEG   = seg_q;
    assign FRAME = frame_q;

endmodule
